soc_bus_fabric: RTL and testbench

//  Parametrised 65xx system-bus fabric: decodes the CPU address into NSLOT peripheral slots plus a default RAM

---
 rtl/soc_bus_fabric_pkg.sv | 19 +
 rtl/soc_bus_fabric_wait_ctrl.sv | 87 ++++++++
 rtl/soc_bus_fabric.sv | 139 +++++++++++++
 tb/tb_soc_bus_fabric.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/soc_bus_fabric_pkg.sv
// soc_bus_fabric_pkg: shared definitions for the system-bus fabric.
//   wait_state_t : wait FSM states (ST_IDLE, ST_WAIT)
//   OPEN_BUS     : value returned on a timed-out read
//   ram_sel_code : select code used for the default RAM slot (= NSLOT)
// Optional feature macro used by the fabric: BUS_TIMEOUT_EN.
package soc_bus_fabric_pkg;

  typedef enum logic {
    ST_IDLE,
    ST_WAIT
  } wait_state_t;

  localparam logic [7:0] OPEN_BUS = 8'hFF;

  function automatic int unsigned ram_sel_code(input int unsigned nslot);
    return nslot;
  endfunction

endpackage

// File: rtl/soc_bus_fabric_wait_ctrl.sv
// bus_wait_ctrl: wait-state FSM for the system-bus fabric.
//   clk, reset_n : clock, asynchronous active-low reset
//   ws           : fixed wait states of the currently decoded slot
//   ready        : ready handshake of the currently decoded slot
//   cpu_rdy      : low = stall the CPU this cycle
//   timeout      : one-cycle pulse on the cycle a stall is forcibly ended
// With BUS_TIMEOUT_EN defined a stall counter ends any stall after TIMEOUT
// cycles; otherwise stalls last until the slot becomes ready.
module bus_wait_ctrl
  import soc_bus_fabric_pkg::*;
#(
  parameter int unsigned WS_W    = 4,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic [WS_W-1:0] ws,
  input  logic            ready,
  output logic            cpu_rdy,
  output logic            timeout
);

  wait_state_t     state_q, state_d, state_nx;
  logic [WS_W-1:0] cnt_q, cnt_d;
  logic            rdy_raw;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rdy_raw = 1'b1;
    case (state_q)
      ST_IDLE: begin
        if (ws != '0 || !ready) begin
          rdy_raw = 1'b0;
          // IDLE already costs one stall cycle, so load N-1.
          cnt_d   = (ws == '0) ? '0 : ws - 1'b1;
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (cnt_q != '0) begin
          rdy_raw = 1'b0;
          cnt_d   = cnt_q - 1'b1;
        end else if (ready) begin
          state_d = ST_IDLE;
        end else begin
          rdy_raw = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

`ifdef BUS_TIMEOUT_EN
  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] stall_q, stall_d;

  assign timeout = !rdy_raw && (stall_q == CW'(TIMEOUT));

  always_comb begin
    stall_d = stall_q + 1'b1;
    if (rdy_raw || timeout) stall_d = '0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) stall_q <= '0;
    else          stall_q <= stall_d;
  end
`else
  assign timeout = 1'b0;
`endif

  assign state_nx = timeout ? ST_IDLE : state_d;
  assign cpu_rdy  = rdy_raw | timeout;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_nx;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: rtl/soc_bus_fabric.sv
// soc_bus_fabric: 65xx system-bus fabric. Decodes cpu_ab into NSLOT
// peripheral slots plus a default RAM slot, drives chip selects and a
// qualified write strobe, returns registered-select read data and stalls
// the CPU through cpu_rdy for per-slot wait states / slot ready.
//   cpu_ab, cpu_we_n      : CPU address and write enable (low = write)
//   cpu_di, cpu_rdy       : read data and ready back to the CPU
//   slot_cs_n, slot_we_n  : per-slot selects, qualified write strobe
//   slot_rdy, slot_do     : per-slot ready and packed read data
//   ram_cs_n, ram_do      : default RAM select and read data
//   bus_err, err_addr     : timeout pulse and last timed-out address
// Optional feature macro: BUS_TIMEOUT_EN (stall timeout, bus error report).
module soc_bus_fabric
  import soc_bus_fabric_pkg::*;
#(
  parameter int unsigned AW        = 20,
  parameter int unsigned NSLOT     = 4,
  parameter int unsigned PAGE_BITS = 8,
  parameter int unsigned SUB_BITS  = 6,
  parameter logic [NSLOT*PAGE_BITS-1:0] SLOT_PAGE = {8'h0f, 8'h0e, 8'h0d, 8'h0d},
  parameter logic [NSLOT*SUB_BITS-1:0]  SLOT_SUB  = {6'h00, 6'h00, 6'h01, 6'h00},
  parameter logic [NSLOT-1:0]           SLOT_SUBEN = 4'b0011,
  parameter int unsigned WS_W      = 4,
  parameter logic [NSLOT*WS_W-1:0]      SLOT_WS   = {4'd0, 4'd0, 4'd2, 4'd1},
  parameter int unsigned TIMEOUT   = 255
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [AW-1:0]      cpu_ab,
  input  logic               cpu_we_n,
  output logic [7:0]         cpu_di,
  output logic               cpu_rdy,
  output logic [NSLOT-1:0]   slot_cs_n,
  output logic               slot_we_n,
  input  logic [NSLOT-1:0]   slot_rdy,
  input  logic [8*NSLOT-1:0] slot_do,
  output logic               ram_cs_n,
  input  logic [7:0]         ram_do,
  output logic               bus_err,
  output logic [AW-1:0]      err_addr
);

  localparam int unsigned SEL_W = $clog2(NSLOT + 1);
  localparam logic [SEL_W-1:0] RAM_SEL = SEL_W'(ram_sel_code(NSLOT));

  logic [PAGE_BITS-1:0] page;
  logic [SUB_BITS-1:0]  sub;
  logic [SEL_W-1:0]     sel_d, sel_q;
  logic [WS_W-1:0]      ws_sel;
  logic                 rdy_sel;
  logic                 found;
  logic                 wait_rdy;
  logic                 timeout;
  logic                 unused_ab;

  assign page      = cpu_ab[AW-1 -: PAGE_BITS];
  assign sub       = cpu_ab[AW-PAGE_BITS-1 -: SUB_BITS];
  assign unused_ab = ^cpu_ab;

  // Lowest hitting slot wins; no hit falls through to RAM.
  always_comb begin
    sel_d = RAM_SEL;
    found = 1'b0;
    for (int unsigned i = 0; i < NSLOT; i++) begin
      if (!found && page == SLOT_PAGE[i*PAGE_BITS +: PAGE_BITS] &&
          (!SLOT_SUBEN[i] || sub == SLOT_SUB[i*SUB_BITS +: SUB_BITS])) begin
        sel_d = SEL_W'(i);
        found = 1'b1;
      end
    end
  end

  always_comb begin
    ws_sel    = '0;
    rdy_sel   = 1'b1;
    slot_cs_n = '1;
    for (int unsigned i = 0; i < NSLOT; i++) begin
      if (sel_d == SEL_W'(i)) begin
        ws_sel       = SLOT_WS[i*WS_W +: WS_W];
        rdy_sel      = slot_rdy[i];
        slot_cs_n[i] = 1'b0;
      end
    end
  end

  assign ram_cs_n = (sel_d != RAM_SEL);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) sel_q <= RAM_SEL;
    else          sel_q <= sel_d;
  end

  bus_wait_ctrl #(
    .WS_W    (WS_W),
    .TIMEOUT (TIMEOUT)
  ) u_wait (
    .clk     (clk),
    .reset_n (reset_n),
    .ws      (ws_sel),
    .ready   (rdy_sel),
    .cpu_rdy (wait_rdy),
    .timeout (timeout)
  );

  // Reset forces ready high and the strobe inactive without waiting for a clock.
  assign cpu_rdy   = wait_rdy | ~reset_n;
  assign slot_we_n = cpu_we_n | ~cpu_rdy | ~reset_n;

  always_comb begin
    cpu_di = ram_do;
    for (int unsigned i = 0; i < NSLOT; i++) begin
      if (sel_q == SEL_W'(i)) cpu_di = slot_do[i*8 +: 8];
    end
    if (timeout) cpu_di = OPEN_BUS;
  end

`ifdef BUS_TIMEOUT_EN
  logic          bus_err_q;
  logic [AW-1:0] err_addr_q, err_addr_d;

  assign err_addr_d = timeout ? cpu_ab : err_addr_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bus_err_q  <= 1'b0;
      err_addr_q <= '0;
    end else begin
      bus_err_q  <= timeout;
      err_addr_q <= err_addr_d;
    end
  end

  assign bus_err  = bus_err_q;
  assign err_addr = err_addr_q;
`else
  assign bus_err  = 1'b0;
  assign err_addr = '0;
`endif

endmodule

// File: tb/tb_soc_bus_fabric.sv
module tb_soc_bus_fabric;

  localparam int AW   = 20;
  localparam int NS   = 4;
  localparam int TOUT = 16;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [AW-1:0] cpu_ab;
  logic          cpu_we_n;
  logic [7:0]    cpu_di;
  logic          cpu_rdy;
  logic [NS-1:0] slot_cs_n;
  logic          slot_we_n;
  logic [NS-1:0] slot_rdy;
  logic [8*NS-1:0] slot_do;
  logic          ram_cs_n;
  logic [7:0]    ram_do;
  logic          bus_err;
  logic [AW-1:0] err_addr;

  soc_bus_fabric #(
    .AW      (AW),
    .NSLOT   (NS),
    .TIMEOUT (TOUT)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .cpu_ab    (cpu_ab),
    .cpu_we_n  (cpu_we_n),
    .cpu_di    (cpu_di),
    .cpu_rdy   (cpu_rdy),
    .slot_cs_n (slot_cs_n),
    .slot_we_n (slot_we_n),
    .slot_rdy  (slot_rdy),
    .slot_do   (slot_do),
    .ram_cs_n  (ram_cs_n),
    .ram_do    (ram_do),
    .bus_err   (bus_err),
    .err_addr  (err_addr)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Slot map as documented: page, sub-page, sub-page enable, wait states.
  int unsigned PG [NS] = '{'h0d, 'h0d, 'h0e, 'h0f};
  int unsigned SB [NS] = '{'h00, 'h01, 'h00, 'h00};
  bit          SE [NS] = '{1'b1, 1'b1, 1'b0, 1'b0};
  int          WS [NS] = '{1, 2, 0, 0};

  int            prev_sel = NS;
  bit            pend_err = 1'b0;
  logic [AW-1:0] pend_addr = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int model_slot(input logic [AW-1:0] a);
    for (int i = 0; i < NS; i++)
      if (int'(a[19:12]) == int'(PG[i]) && (!SE[i] || int'(a[11:6]) == int'(SB[i])))
        return i;
    return NS;
  endfunction

  function automatic logic [7:0] data_of(input int s);
    if (s == NS) return ram_do;
    return slot_do[s*8 +: 8];
  endfunction

  task automatic drive_rdy(input int s, input int k, input int r);
    logic [NS-1:0] m;
    m = NS'($urandom);
    if (s < NS) m[s] = (k >= r);
    slot_rdy = m;
  endtask

  // One CPU access: slot_rdy of the target is low for the first r cycles.
  // Completion happens on cycle max(WS, r); RAM never stalls.
  task automatic run_txn(input logic [AW-1:0] a, input logic we, input int r);
    int s, stall;
    bit timed;
    logic [NS-1:0] cs_exp;
    s     = model_slot(a);
    stall = (s == NS) ? 0 : ((WS[s] > r) ? WS[s] : r);
    timed = 1'b0;
`ifdef BUS_TIMEOUT_EN
    if (stall > TOUT) begin
      stall = TOUT;
      timed = 1'b1;
    end
`endif
    cs_exp = '1;
    if (s < NS) cs_exp[s] = 1'b0;
    @(posedge clk); #1;
    cpu_ab   = a;
    cpu_we_n = we;
    slot_do  = $urandom;
    ram_do   = 8'($urandom);
    drive_rdy(s, 0, r);
    for (int k = 0; k <= stall; k++) begin
      if (k > 0) begin
        @(posedge clk); #1;
        drive_rdy(s, k, r);
      end
      @(negedge clk);
      if (k == 0) begin
        chk("rd_data", 32'(cpu_di), 32'(data_of(prev_sel)));
        chk("bus_err", 32'(bus_err), 32'(pend_err));
        if (pend_err) chk("err_addr", 32'(err_addr), 32'(pend_addr));
      end
      chk("slot_cs_n", 32'(slot_cs_n), 32'(cs_exp));
      chk("ram_cs_n", 32'(ram_cs_n), 32'(s != NS));
      chk("cpu_rdy", 32'(cpu_rdy), 32'(k == stall));
      chk("slot_we_n", 32'(slot_we_n), 32'(we | (k != stall)));
      if (timed && k == stall) chk("open_bus", 32'(cpu_di), 32'h0000_00ff);
    end
    prev_sel  = s;
    pend_err  = timed;
    pend_addr = a;
  endtask

  initial begin
    logic [AW-1:0] a;
    int pick;

    reset_n  = 1'b0;
    cpu_ab   = 20'h12345;
    cpu_we_n = 1'b0;
    slot_rdy = '1;
    slot_do  = $urandom;
    ram_do   = 8'($urandom);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_rdy", 32'(cpu_rdy), 32'd1);
    chk("rst_we_n", 32'(slot_we_n), 32'd1);
    chk("rst_data", 32'(cpu_di), 32'(ram_do));
    chk("rst_bus_err", 32'(bus_err), 32'd0);
    chk("rst_err_addr", 32'(err_addr), 32'd0);
    chk("rst_ram_cs", 32'(ram_cs_n), 32'd0);
    cpu_we_n = 1'b1;
    @(posedge clk); #1;
    reset_n = 1'b1;

    // Directed accesses from the slot map.
    run_txn(20'h0E123, 1'b1, 0);
    run_txn(20'h0D040, 1'b1, 0);
    run_txn(20'h0D000, 1'b0, 0);
    run_txn(20'h0D080, 1'b1, 0);
    run_txn(20'h12345, 1'b0, 0);
    run_txn(20'h0D040, 1'b1, 7);
    run_txn(20'h0F3FF, 1'b0, 3);
    run_txn(20'h0D000, 1'b1, 4);

    // Reset during a stuck stall releases the CPU at once.
    @(posedge clk); #1;
    cpu_ab   = 20'h0D040;
    cpu_we_n = 1'b0;
    slot_rdy = '0;
    repeat (3) begin
      @(negedge clk);
      chk("stall_pre_rst", 32'(cpu_rdy), 32'd0);
    end
    #1 reset_n = 1'b0;
    #1;
    chk("mid_rst_rdy", 32'(cpu_rdy), 32'd1);
    chk("mid_rst_we_n", 32'(slot_we_n), 32'd1);
    chk("mid_rst_data", 32'(cpu_di), 32'(ram_do));
    cpu_ab   = 20'h12345;
    cpu_we_n = 1'b1;
    slot_rdy = '1;
    @(posedge clk); #1;
    reset_n  = 1'b1;
    prev_sel = NS;
    pend_err = 1'b0;

`ifdef BUS_TIMEOUT_EN
    run_txn(20'h0D040, 1'b1, 1000);
    run_txn(20'h12345, 1'b1, 0);
    run_txn(20'h0E001, 1'b0, 1000);
    run_txn(20'h0D000, 1'b1, 0);
`endif

    // Randomized accesses.
    for (int t = 0; t < 300; t++) begin
      pick = $urandom_range(0, 5);
      case (pick)
        0: a = 20'h0D000 | AW'($urandom_range(0, 63));
        1: a = 20'h0D040 | AW'($urandom_range(0, 63));
        2: a = 20'h0E000 | AW'($urandom_range(0, 4095));
        3: a = 20'h0F000 | AW'($urandom_range(0, 4095));
        4: a = 20'h0D080 | AW'($urandom_range(0, 3967));
        default: a = AW'($urandom);
      endcase
      run_txn(a, 1'($urandom), $urandom_range(0, 10));
    end
    run_txn(20'h12345, 1'b1, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
